// File: rtl/sblk_pkg.sv
// sblk_pkg: shared superblock activation defaults and word type
package sblk_pkg;
    localparam int DEF_WID_ACT    = 16;
    localparam int DEF_N_ROW      = 12;
    localparam int DEF_FIFO_DEPTH = 4;
    typedef logic [2*DEF_WID_ACT-1:0] act_word_t;
endpackage

// File: rtl/act_feed_fifo.sv
// act_feed_fifo: synchronous per-row word FIFO with pointers, occupancy count and clear
module act_feed_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_l,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic push_ok, pop_ok;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign head    = mem[rd_q];
    assign push_ok = push & ~full & ~clr;
    assign pop_ok  = pop & ~empty & ~clr;
    // next pointers and occupancy; clear overrides push and pop
    always_comb begin
        wr_d  = clr ? '0 : wr_q + AW'(push_ok);
        rd_d  = clr ? '0 : rd_q + AW'(pop_ok);
        cnt_d = clr ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    // pointer/count registers; storage array is not reset
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        if (push_ok) mem[wr_q] <= din;
    end
endmodule

// File: rtl/act_row_feeder.sv
// act_row_feeder: steers/broadcasts activation words into per-row FIFOs and feeds rows under req
module act_row_feeder
    import sblk_pkg::*;
#(
    parameter int N_ROW      = DEF_N_ROW,
    parameter int WID_ACT    = DEF_WID_ACT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int WID_ROW    = $clog2(N_ROW)
) (
    input  logic                       clk_l,
    input  logic                       rst_n,
    input  logic [2*WID_ACT-1:0]       in_data,
    input  logic [WID_ROW-1:0]         in_row,
    input  logic                       in_bcast,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic                       flush,
    output logic [2*WID_ACT*N_ROW-1:0] act_data_in,
    output logic [N_ROW-1:0]           act_data_in_vld,
    input  logic [N_ROW-1:0]           act_data_in_req,
    output logic                       idle,
    output logic                       err_row
);
    localparam int WW = 2*WID_ACT;
    localparam int NX = 1 << WID_ROW;
    logic [N_ROW-1:0] full, empty, push, pop;
    logic [NX-1:0] full_x;
    logic [WW-1:0] head [N_ROW];
    logic in_range, acc;
    logic [WW*N_ROW-1:0] data_q, data_d;
    logic [N_ROW-1:0] vld_q, vld_d;
    logic err_q, err_d;
    // out-of-range rows index the zero-padded tail, so they always read as not full
    assign in_range        = {1'b0, in_row} < (WID_ROW+1)'(N_ROW);
    assign full_x          = NX'(full);
    assign in_rdy          = ~flush & (in_bcast ? ~|full : (~in_range | ~full_x[in_row]));
    assign acc             = in_vld & in_rdy;
    assign act_data_in     = data_q;
    assign act_data_in_vld = vld_q;
    assign err_row         = err_q;
    assign idle            = &empty & ~|vld_q;
    // steer accepted words, pop requested non-empty rows, capture popped heads
    always_comb begin
        push   = '0;
        pop    = '0;
        vld_d  = '0;
        data_d = data_q;
        for (int r = 0; r < N_ROW; r++) begin
            push[r]  = acc & (in_bcast | (in_range & (in_row == WID_ROW'(r))));
            pop[r]   = ~flush & act_data_in_req[r] & ~empty[r];
            vld_d[r] = pop[r];
            if (pop[r]) data_d[r*WW +: WW] = head[r];
        end
        err_d = ~flush & (err_q | (acc & ~in_bcast & ~in_range));
    end
    // per-row output registers and sticky range error
    always_ff @(posedge clk_l) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
        end
    end
    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        act_feed_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_l (clk_l),
            .rst_n (rst_n),
            .clr   (flush),
            .push  (push[r]),
            .pop   (pop[r]),
            .din   (in_data),
            .full  (full[r]),
            .empty (empty[r]),
            .head  (head[r])
        );
    end
endmodule

// File: tb/tb_act_row_feeder.sv
// tb_act_row_feeder: directed self-checking bench for act_row_feeder
module tb_act_row_feeder;
    import sblk_pkg::*;
    logic clk_l, rst_n, in_bcast, in_vld, in_rdy, flush, idle, err_row;
    act_word_t in_data;
    logic [3:0] in_row;
    logic [383:0] act_data_in;
    logic [11:0] act_data_in_vld, req;
    int checks = 0;
    int failures = 0;

    act_row_feeder dut (
        .clk_l           (clk_l),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_row          (in_row),
        .in_bcast        (in_bcast),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .flush           (flush),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (req),
        .idle            (idle),
        .err_row         (err_row)
    );

    initial clk_l = 1'b0;
    always #5 clk_l = ~clk_l;

    task automatic tick;
        @(posedge clk_l);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic act_word_t sl(input int r);
        return act_data_in[r*32 +: 32];
    endfunction

    initial begin
        bit pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        act_word_t ed [5] = '{32'hD000_0000, 32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0002};
        rst_n = 1'b0; in_data = '0; in_row = '0; in_bcast = 1'b0; in_vld = 1'b0; flush = 1'b0; req = '0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("rst_idle", idle, 1);
        chk("rst_vld", act_data_in_vld, 0);
        chk("rst_err", err_row, 0);
        chk("rst_data", |act_data_in, 0);
        in_row = 4'd3; in_data = 32'h1234_5678; in_vld = 1'b1; req = 12'h008;
        #1 chk("t1_rdy", in_rdy, 1);
        tick;
        in_vld = 1'b0;
        chk("t1_vld_early", act_data_in_vld, 0);
        tick;
        chk("t1_vld", act_data_in_vld, 12'h008);
        chk("t1_data", sl(3), 32'h1234_5678);
        tick;
        chk("t1_vld_off", act_data_in_vld, 0);
        chk("t1_idle", idle, 1);
        req = '0; in_bcast = 1'b1; in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA000_0000 + i;
            #1 chk("t2_bc_rdy", in_rdy, 1);
            tick;
        end
        in_vld = 1'b0;
        #1 chk("t2_bc_full", in_rdy, 0);
        chk("t2_not_idle", idle, 0);
        req = 12'h001;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t2_r0_vld", act_data_in_vld, 12'h001);
            chk("t2_r0_data", sl(0), 32'hA000_0000 + i);
            chk("t2_bc_blocked", in_rdy, 0);
        end
        req = 12'hFFF;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t2_rest_vld", act_data_in_vld, 12'hFFE);
            chk("t2_r11_data", sl(11), 32'hA000_0000 + i);
            chk("t2_r6_data", sl(6), 32'hA000_0000 + i);
            if (i == 0) chk("t2_bc_rdy_again", in_rdy, 1);
        end
        req = '0;
        tick;
        chk("t2_vld_off", act_data_in_vld, 0);
        chk("t2_idle", idle, 1);
        in_bcast = 1'b0; in_row = 4'd7; in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hB000_0000 + i;
            #1 chk("t3_rdy", in_rdy, 1);
            tick;
        end
        in_data = 32'hB000_0004;
        #1 chk("t3_full", in_rdy, 0);
        tick;
        chk("t3_held", in_rdy, 0);
        chk("t3_no_vld", act_data_in_vld, 0);
        req = 12'h080;
        #1 chk("t3_full_before_pop", in_rdy, 0);
        tick;
        req = '0;
        chk("t3_pulse_vld", act_data_in_vld, 12'h080);
        chk("t3_pulse_data", sl(7), 32'hB000_0000);
        #1 chk("t3_rdy_after_pop", in_rdy, 1);
        tick;
        in_vld = 1'b0;
        chk("t3_vld_off", act_data_in_vld, 0);
        req = 12'h080;
        for (int i = 1; i < 5; i++) begin
            tick;
            chk("t3_drain_vld", act_data_in_vld, 12'h080);
            chk("t3_drain_data", sl(7), 32'hB000_0000 + i);
        end
        req = '0;
        tick;
        chk("t3_idle", idle, 1);
        in_row = 4'd12; in_data = 32'hDEAD_BEEF; in_vld = 1'b1;
        #1 chk("t4_oor_rdy", in_rdy, 1);
        tick;
        in_vld = 1'b0;
        chk("t4_err", err_row, 1);
        chk("t4_idle", idle, 1);
        tick;
        chk("t4_err_sticky", err_row, 1);
        chk("t4_no_vld", act_data_in_vld, 0);
        in_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_row = 4'd2; in_data = 32'hC200_0000 + i;
            tick;
            in_row = 4'd5; in_data = 32'hC500_0000 + i;
            tick;
        end
        chk("t5_not_idle", idle, 0);
        flush = 1'b1; req = 12'hFFF; in_row = 4'd2; in_data = 32'hF00D_F00D;
        #1 chk("t5_flush_rdy", in_rdy, 0);
        tick;
        flush = 1'b0; in_vld = 1'b0;
        chk("t5_flush_vld", act_data_in_vld, 0);
        chk("t5_flush_err", err_row, 0);
        chk("t5_flush_idle", idle, 1);
        tick;
        chk("t5_post_vld", act_data_in_vld, 0);
        chk("t5_post_idle", idle, 1);
        req = '0; in_row = 4'd1; in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hD000_0000 + i;
            tick;
        end
        in_vld = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req = pat[k] ? 12'h002 : 12'h000;
            tick;
            chk("t6_vld", act_data_in_vld, pat[k] ? 12'h002 : 12'h000);
            chk("t6_data", sl(1), ed[k]);
        end
        chk("t6_not_idle", idle, 0);
        rst_n = 1'b0; req = 12'h002;
        tick;
        chk("t7_rst_vld", act_data_in_vld, 0);
        chk("t7_rst_data", sl(1), 0);
        chk("t7_rst_idle", idle, 1);
        rst_n = 1'b1;
        tick;
        chk("t7_post_vld", act_data_in_vld, 0);
        req = '0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/act_row_feeder.md
# act_row_feeder

Activation feeder sitting directly upstream of the superblock row. It accepts one serial stream of double-width activation words from the activation buffer controller, steers each word to one row or broadcasts it to all rows, and buffers words per row. It drives each row's `act_data_in` / `act_data_in_vld` strictly under that row's `act_data_in_req` flow control.

## Interface
- `N_ROW`, 12, number of superblock rows fed.
- `WID_ACT`, 16, activation element width; each word is `2*WID_ACT` bits.
- `FIFO_DEPTH`, 4, per-row buffer depth in words; power of two, ≥2.
- `WID_ROW`, `$clog2(N_ROW)`, row index width.

Ports:
- `clk_l`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  `2*WID_ACT`  activation word.
- `in_row`  in  `WID_ROW`  destination row; ignored when `in_bcast`=1.
- `in_bcast`  in  1  write word to all rows.
- `in_vld`  in  1  word valid.
- `in_rdy`  out  1  word accepted when `in_vld & in_rdy`.
- `flush`  in  1  synchronous clear of all buffered words.
- `act_data_in`  out  `2*WID_ACT*N_ROW`  per-row data; row r at `[r*2*WID_ACT +: 2*WID_ACT]`.
- `act_data_in_vld`  out  `N_ROW`  per-row one-cycle valid.
- `act_data_in_req`  in  `N_ROW`  per-row request from superblock.
- `idle`  out  1  all FIFOs empty and no `act_data_in_vld` bit set.
- `err_row`  out  1  sticky: a word with `in_row` ≥ `N_ROW` was presented.

## Operation
- Input:
  - Unicast: `in_rdy` = `!full[in_row]`, or 1 if `in_row` ≥ `N_ROW`. An accepted out-of-range word is dropped and sets `err_row`.
  - Broadcast: `in_rdy` = AND of `!full[r]` over all rows. An accepted word is pushed into every FIFO in the same cycle. No partial broadcast.
  - `in_rdy` is combinational from FIFO full flags, `in_row` and `in_bcast`; it never depends on `in_vld`.
  - Full is evaluated before a same-cycle pop. A full FIFO refuses a push even when it pops that cycle.
- Output, per row r, independent of other rows:
  - If `act_data_in_req[r]`=1 and FIFO r is non-empty at the edge: pop the head, register it into `act_data_in` slice r, and set `act_data_in_vld[r]`=1 for the next cycle.
  - Otherwise `act_data_in_vld[r]`=0 and the data slice holds its last value.
- Req contract: `act_data_in_vld` lags `req` by one cycle. The superblock therefore absorbs one word arriving the cycle after it drops `req`. Continuous `req` with a non-empty FIFO yields one word per cycle.
- Ordering: per row, words leave in acceptance order. Broadcast and unicast words interleave in acceptance order.
- `flush`=1 takes priority over push and pop in that cycle:
  - empties all FIFOs, clears `act_data_in_vld` and `err_row`;
  - forces `in_rdy`=0 that cycle.

## Timing
- Reset (`rst_n`=0 at edge):
  - all FIFOs empty; `act_data_in`=0, `act_data_in_vld`=0, `err_row`=0;
  - `idle`=1, and `in_rdy`=1 for any in-range row.
- Latency: word accepted at edge t → visible at FIFO head after t. If `req[r]`=1 at edge t+1, `act_data_in_vld[r]`=1 during cycle t+1→t+2. Minimum 2 cycles input-to-output.
- Throughput:
  - unicast: 1 word/cycle into distinct or same row while not full;
  - output: each row 1 word/cycle concurrently.
- Reset or flush mid-transfer: buffered words are discarded and no `vld` is emitted the following cycle. Any word offered in the flush cycle is not accepted.
- `idle` is combinational from FIFO empty flags and `act_data_in_vld`.

## Structure
- Shared package `sblk_pkg`: `WID_ACT`, `N_ROW`, `FIFO_DEPTH` defaults and the `act_word_t` typedef (`logic [2*WID_ACT-1:0]`).
- Sub-module `act_feed_fifo`: synchronous FIFO, parameters `WIDTH` and `DEPTH`.
  - Read/write pointers plus occupancy count; outputs `full`, `empty`, `head`; synchronous clear input.
  - Instantiated `N_ROW` times in a generate loop.
- Top level holds the input steering and ready logic, the per-row output registers, `err_row` and `idle`.

## Test plan
- Reset then unicast `in_row`=3, `in_data`=0x1234_5678, `req[3]`=1 held → `act_data_in_vld[3]` high exactly one cycle, 2 cycles after acceptance, with slice 3 = 0x12345678; other `vld` bits stay 0.
- Broadcast 4 words with all `req`=0 → all FIFOs full and `in_rdy`=0. Raise `req[0]` only → row 0 emits 4 words in order; `in_rdy` for broadcast stays 0 until the other rows drain.
- Unicast 5 words to row 7 with `req[7]`=0 → first 4 accepted, 5th held with `in_rdy`=0. Pulse `req[7]` one cycle → one word out, the 5th is accepted the following cycle.
- `in_row`=12 with `in_vld`=1 → accepted (`in_rdy`=1), no row receives it, `err_row`=1 until `flush`.
- Fill rows 2 and 5 with 3 words each, assert `flush` for 1 cycle with `req` high and `in_vld` high → `in_rdy`=0 that cycle, no `vld` afterwards, `idle`=1.
- `req[1]` toggling 1,0,1,1,0 with 4 buffered words → `vld[1]` pattern 1,0,1,1,0, delayed one cycle; data in FIFO order.
